gshare_branch_pred: RTL
=======================

Name: gshare_branch_pred

Overview:
- Clocked, parametrised successor to the correlating branch predictor in the pipelined processor.
- IF stage sends branch PCs; the block returns a taken/not-taken prediction one cycle later.
- In-flight predictions are held in an in-order FIFO together with their GHR checkpoint, until EX resolves them.
- On a mispredict it repairs the global history, flushes younger entries and pulses mispredict.

Parameters:
- PC_IDX_BITS, 6: PHT index width; PHT depth is 2**PC_IDX_BITS.
- GHR_BITS, 4: global history length; must be <= PC_IDX_BITS.
- CTR_BITS, 2: saturating counter width; the counter MSB is the prediction.
- INFLIGHT, 4: unresolved-branch FIFO depth; must be a power of 2 and >= 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- pred_req  in  1  IF requests a prediction.
- pred_pc  in  32  branch instruction address.
- pred_ready  out  1  high when the FIFO is not full.
- pred_valid  out  1  registered; prediction valid this cycle.
- prediction  out  1  registered; 1 = taken.
- resolve_valid  in  1  EX resolved the oldest in-flight branch (replaces branch_EX_done).
- actual_outcome  in  1  resolved direction.
- mispredict  out  1  registered one-cycle pulse.
- inflight_cnt  out  $clog2(INFLIGHT)+1  FIFO occupancy.
- resolve_err  out  1  sticky; set by a resolve while the FIFO is empty.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - every PHT counter set to weakly not-taken (01 for CTR_BITS=2, i.e. 2**(CTR_BITS-1)-1);
  - GHR=0, FIFO empty;
  - pred_valid=0, prediction=0, mispredict=0, inflight_cnt=0, resolve_err=0;
  - reset mid-operation discards all in-flight entries.
- Index: idx = pred_pc[PC_IDX_BITS+1:2] XOR {zeros, GHR}.
- Accept: predict is accepted when pred_req && pred_ready && no mispredict in the same cycle.
  - Next cycle: pred_valid=1, prediction = PHT[idx] MSB.
  - Push {idx, prediction, GHR} into the FIFO.
  - Speculative GHR update: GHR = {GHR[GHR_BITS-2:0], prediction}.
  - pred_req while pred_ready=0 is ignored; pred_valid=0 next cycle.
- Resolve (resolve_valid, FIFO not empty): pop the head entry.
  - PHT[head.idx] saturating +1 if actual_outcome=1, -1 if 0; no wrap past all-1s or 0.
  - If actual_outcome != head.prediction: mispredict=1 next cycle; all FIFO entries flushed; GHR = {head.ghr[GHR_BITS-2:0], actual_outcome}.
  - If actual_outcome == head.prediction: GHR and the other entries are untouched.
- Resolve with the FIFO empty: ignored, resolve_err set to 1 and held until rst.
- Simultaneous predict and resolve in the same cycle:
  - The PHT read uses the pre-update value (read-before-write), even at an equal index.
  - Pop and push both happen, so occupancy is unchanged.
  - On a correct resolve, GHR takes the speculative shift.
  - On a mispredict, the predict is discarded and the repaired GHR wins.
- Full: pred_ready=0 when inflight_cnt==INFLIGHT; a resolve that cycle frees the slot for the next cycle, with no combinational bypass.
- Latency: prediction 1 cycle; PHT update is visible to reads from the cycle after the resolve.

Optional Feature:
- Macro GSHARE_PRED_STATS_EN.
- When defined: adds outputs stat_preds[31:0] and stat_mispreds[31:0].
  - They count accepted predictions and mispredicts, saturate at 2**32-1 and clear on rst.
- When undefined: no counters and no extra ports; all other behaviour is identical.

Decomposition:
- Shared package bp_pkg holds:
  - the counter constants CTR_WNT and CTR_MAX;
  - a fifo entry typedef {idx, pred, ghr};
  - the saturating-increment/decrement function.
- One natural sub-module, bp_inflight_fifo: in-order FIFO with push, pop, flush and count, parametrised on depth and entry width.

Test Plan:
- Reset, then predict pc=0x0C → pred_valid=1 next cycle, prediction=0; GHR=0b0000 before and after (speculative bit 0).
- Resolve pc=0x0C with actual=1 → mispredict pulse; GHR=0b0001; FIFO empty; PHT[3] counter=10.
- Predict pc=0x0C again with GHR=0001 → idx=2, weakly not-taken → prediction=0, showing history steers the index.
- Push 4 predictions (0x08, 0x2C, 0x6C, 0x00) without resolving → pred_ready=0, inflight_cnt=4, 5th request ignored; one correct resolve (actual=0) → pred_ready=1 next cycle.
- With 3 in flight, resolve the head wrongly while pred_req is high → mispredict=1, inflight_cnt=0, concurrent predict dropped, GHR=head.ghr shifted with actual.
- resolve_valid with the FIFO empty → resolve_err=1 and stays 1; rst mid-stream → all outputs at reset values; counter saturation checked by 5 taken resolves at one index (holds at 11).

Source files
------------

// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the gshare branch predictor:
//   - width-agnostic helpers for the saturating direction counters
//     (weakly-not-taken value, counter maximum, +/-1 saturating step);
//   - CTR_WNT / CTR_MAX for the default 2-bit counter;
//   - bp_entry_t, the in-flight entry {idx, pred, ghr} at the default widths.
// The predictor top builds a parametrised copy of the same entry layout so
// that non-default configurations stay consistent.
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int unsigned BP_PC_IDX_BITS = 6;
    localparam int unsigned BP_GHR_BITS    = 4;
    localparam int unsigned BP_CTR_BITS    = 2;

    // Weakly-not-taken value for a counter of the given width: 2**(bits-1)-1.
    function automatic logic [31:0] ctr_wnt_of(input int unsigned bits);
        return (32'd1 << (bits - 32'd1)) - 32'd1;
    endfunction

    // All-ones value for a counter of the given width.
    function automatic logic [31:0] ctr_max_of(input int unsigned bits);
        logic [31:0] res;
        if (bits >= 32'd32) begin
            res = 32'hFFFF_FFFF;
        end else begin
            res = (32'd1 << bits) - 32'd1;
        end
        return res;
    endfunction

    // Saturating step: +1 when up, -1 otherwise, clamped to [0, ctr_max].
    function automatic logic [31:0] sat_step(input logic [31:0] ctr,
                                             input logic [31:0] ctr_max,
                                             input logic        up);
        logic [31:0] res;
        if (up) begin
            if (ctr >= ctr_max) begin
                res = ctr_max;
            end else begin
                res = ctr + 32'd1;
            end
        end else begin
            if (ctr == 32'd0) begin
                res = 32'd0;
            end else begin
                res = ctr - 32'd1;
            end
        end
        return res;
    endfunction

    localparam logic [BP_CTR_BITS-1:0] CTR_WNT = BP_CTR_BITS'(ctr_wnt_of(BP_CTR_BITS));
    localparam logic [BP_CTR_BITS-1:0] CTR_MAX = BP_CTR_BITS'(ctr_max_of(BP_CTR_BITS));

    typedef struct packed {
        logic [BP_PC_IDX_BITS-1:0] idx;
        logic                      pred;
        logic [BP_GHR_BITS-1:0]    ghr;
    } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// ---------------------------------------------------------------------------
// bp_inflight_fifo
// In-order FIFO holding unresolved branch predictions.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push          write push_data at the tail (ignored when full)
//   push_data     entry to store
//   pop           drop the head entry (ignored when empty)
//   flush         discard every entry; overrides push and pop
//   head_data     oldest entry (undefined content when empty)
//   count         occupancy, 0..DEPTH
//   empty, full   occupancy flags
// DEPTH must be a power of two and >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module bp_inflight_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             empty_s;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Occupancy flags and qualified push/pop strobes.
    always_comb begin
        empty_s   = (count_r == {(AW+1){1'b0}});
        full_s    = (count_r == (AW+1)'(DEPTH));
        do_push_s = push && !full_s && !flush;
        do_pop_s  = pop && !empty_s && !flush;
    end

    // Entry storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties the queue like a reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign empty     = empty_s;
    assign full      = full_s;

endmodule

// File: rtl/gshare_branch_pred.sv
// ---------------------------------------------------------------------------
// gshare_branch_pred
// Gshare direction predictor: PHT of saturating counters indexed by
// pc[PC_IDX_BITS+1:2] XOR global history. Predictions return one cycle after
// the request and are queued in order with their history checkpoint until
// EX resolves them. A mispredict repairs the history from the checkpoint,
// flushes all younger in-flight entries and pulses mispredict.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pred_req/pred_pc  prediction request from IF
//   pred_ready        FIFO not full
//   pred_valid        registered: prediction valid this cycle
//   prediction        registered: 1 = taken
//   resolve_valid     EX resolves the oldest in-flight branch
//   actual_outcome    resolved direction
//   mispredict        registered one-cycle pulse
//   inflight_cnt      FIFO occupancy
//   resolve_err       sticky: resolve seen with nothing in flight
// Optional (macro GSHARE_PRED_STATS_EN):
//   stat_preds, stat_mispreds  saturating 32-bit event counters
// GHR_BITS must be >= 2 and <= PC_IDX_BITS.
// ---------------------------------------------------------------------------
module gshare_branch_pred
    import bp_pkg::*;
#(
    parameter int unsigned PC_IDX_BITS = 6,
    parameter int unsigned GHR_BITS    = 4,
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned INFLIGHT    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pred_req,
    input  logic [31:0]                 pred_pc,
    output logic                        pred_ready,
    output logic                        pred_valid,
    output logic                        prediction,
    input  logic                        resolve_valid,
    input  logic                        actual_outcome,
    output logic                        mispredict,
    output logic [$clog2(INFLIGHT):0]   inflight_cnt,
    output logic                        resolve_err
`ifdef GSHARE_PRED_STATS_EN
    ,
    output logic [31:0]                 stat_preds,
    output logic [31:0]                 stat_mispreds
`endif
);

    localparam int unsigned PHT_DEPTH = 1 << PC_IDX_BITS;
    localparam int unsigned CNT_W     = $clog2(INFLIGHT) + 1;
    localparam int unsigned ENTRY_W   = PC_IDX_BITS + 1 + GHR_BITS;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_wnt_of(CTR_BITS));
    localparam logic [31:0]         CTR_TOP = ctr_max_of(CTR_BITS);

    typedef struct packed {
        logic [PC_IDX_BITS-1:0] idx;
        logic                   pred;
        logic [GHR_BITS-1:0]    ghr;
    } entry_t;

    logic [CTR_BITS-1:0]    pht_r [PHT_DEPTH];
    logic [GHR_BITS-1:0]    ghr_r;
    logic                   pred_valid_r;
    logic                   prediction_r;
    logic                   mispredict_r;
    logic                   resolve_err_r;

    logic [PC_IDX_BITS-1:0] idx_s;
    logic                   pred_bit_s;
    logic                   resolve_ok_s;
    logic                   mis_s;
    logic                   accept_s;
    logic                   err_set_s;
    logic [GHR_BITS-1:0]    ghr_next_s;
    logic [CTR_BITS-1:0]    ctr_next_s;
    entry_t                 push_entry_s;
    entry_t                 head_entry_s;
    logic [ENTRY_W-1:0]     head_bits_s;
    logic [CNT_W-1:0]       fifo_cnt_s;
    logic                   fifo_empty_s;
    logic                   fifo_full_s;
    logic                   unused_bits_s;

    // Lookup, resolve qualification, history and counter next-state.
    always_comb begin
        head_entry_s = entry_t'(head_bits_s);
        idx_s        = pred_pc[PC_IDX_BITS+1:2] ^ PC_IDX_BITS'(ghr_r);
        pred_bit_s   = pht_r[idx_s][CTR_BITS-1];
        resolve_ok_s = resolve_valid && !fifo_empty_s;
        err_set_s    = resolve_valid && fifo_empty_s;
        mis_s        = resolve_ok_s && (actual_outcome != head_entry_s.pred);
        // A mispredict in the same cycle kills the request: it is younger
        // than the branch being repaired.
        accept_s     = pred_req && !fifo_full_s && !mis_s;
        push_entry_s = '{idx: idx_s, pred: pred_bit_s, ghr: ghr_r};
        ctr_next_s   = CTR_BITS'(sat_step(32'(pht_r[head_entry_s.idx]), CTR_TOP, actual_outcome));
        ghr_next_s   = ghr_r;
        if (mis_s) begin
            ghr_next_s = {head_entry_s.ghr[GHR_BITS-2:0], actual_outcome};
        end else if (accept_s) begin
            ghr_next_s = {ghr_r[GHR_BITS-2:0], pred_bit_s};
        end else begin
            ghr_next_s = ghr_r;
        end
        // The checkpoint MSB is shifted out on repair and pc bits outside
        // the index field do not take part in the hash.
        unused_bits_s = ^{pred_pc[31:PC_IDX_BITS+2], pred_pc[1:0],
                          head_entry_s.ghr[GHR_BITS-1]};
    end

    // Pattern history table: written only by resolves, so a same-cycle
    // lookup always sees the pre-update counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(PHT_DEPTH); i++) begin
                pht_r[i] <= CTR_RST;
            end
        end else if (resolve_ok_s) begin
            pht_r[head_entry_s.idx] <= ctr_next_s;
        end
    end

    // History register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_r         <= {GHR_BITS{1'b0}};
            pred_valid_r  <= 1'b0;
            prediction_r  <= 1'b0;
            mispredict_r  <= 1'b0;
            resolve_err_r <= 1'b0;
        end else begin
            ghr_r         <= ghr_next_s;
            pred_valid_r  <= accept_s;
            prediction_r  <= accept_s & pred_bit_s;
            mispredict_r  <= mis_s;
            resolve_err_r <= resolve_err_r | err_set_s;
        end
    end

    bp_inflight_fifo #(
        .DEPTH (INFLIGHT),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept_s),
        .push_data (push_entry_s),
        .pop       (resolve_ok_s),
        .flush     (mis_s),
        .head_data (head_bits_s),
        .count     (fifo_cnt_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    assign pred_ready   = !fifo_full_s;
    assign pred_valid   = pred_valid_r;
    assign prediction   = prediction_r;
    assign mispredict   = mispredict_r;
    assign inflight_cnt = fifo_cnt_s;
    assign resolve_err  = resolve_err_r;

`ifdef GSHARE_PRED_STATS_EN
    logic [31:0] stat_preds_r;
    logic [31:0] stat_mispreds_r;

    // Saturating event counters for accepted predictions and mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_preds_r    <= 32'd0;
            stat_mispreds_r <= 32'd0;
        end else begin
            if (accept_s && (stat_preds_r != 32'hFFFF_FFFF)) begin
                stat_preds_r <= stat_preds_r + 32'd1;
            end
            if (mis_s && (stat_mispreds_r != 32'hFFFF_FFFF)) begin
                stat_mispreds_r <= stat_mispreds_r + 32'd1;
            end
        end
    end

    assign stat_preds    = stat_preds_r;
    assign stat_mispreds = stat_mispreds_r;
`endif

endmodule
